// File: rtl/frame_buf_ctrl_pkg.sv
// Shared constants and types for the ping-pong frame buffer controller.
package frame_buf_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF       = 16;
  localparam int unsigned FRAME_ADDR_WIDTH_DEF = 2;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SCAN = 1'b1
  } rd_state_e;

  // Memory address = {bank, frame pointer}.
  function automatic int unsigned mem_addr_width(input int unsigned frame_addr_width);
    return frame_addr_width + 1;
  endfunction

endpackage

// File: rtl/frame_buf_ctrl_frame_ptr.sv
// Frame pointer plus bank select. The pointer wraps on its own; the bank bit
// only toggles on an explicit swap and is never carried into.
module frame_buf_ctrl_frame_ptr
  import frame_buf_ctrl_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = FRAME_ADDR_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic                 swap,
  output logic [PTR_WIDTH-1:0] ptr,
  output logic                 bank,
  output logic                 last
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr  <= '0;
      bank <= BANK0;
    end else begin
      if (step) ptr <= ptr + 1'b1;
      if (swap) bank <= ~bank;
    end
  end

  assign last = &ptr;

endmodule

// File: rtl/frame_buf_ctrl.sv
// Ping-pong frame controller: fills one memory bank from the pixel stream while
// the other is scanned out, repeating the last complete frame until a newer one lands.
//
//  state   | meaning
//  RD_IDLE | read bank holds no complete frame, no reads issued
//  RD_SCAN | read bank full, one read issued per out_ready cycle
module frame_buf_ctrl
  import frame_buf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int unsigned FRAME_ADDR_WIDTH = FRAME_ADDR_WIDTH_DEF,
  localparam int unsigned MEM_ADDR_WIDTH  = mem_addr_width(FRAME_ADDR_WIDTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic                      mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_sof,
  output logic [1:0]                bank_full
);

  logic [FRAME_ADDR_WIDTH-1:0] w_ptr, r_ptr;
  logic                        w_bank, r_bank, w_last, r_last;
  logic                        wr_xfer, w_done;
  logic                        rd_issue, r_end, r_swap, r_other;
  logic [1:0]                  bank_full_nxt;
  rd_state_e                   rd_state;

  frame_buf_ctrl_frame_ptr #(.PTR_WIDTH(FRAME_ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .step  (wr_xfer),
    .swap  (w_done),
    .ptr   (w_ptr),
    .bank  (w_bank),
    .last  (w_last)
  );

  frame_buf_ctrl_frame_ptr #(.PTR_WIDTH(FRAME_ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .step  (rd_issue),
    .swap  (r_swap),
    .ptr   (r_ptr),
    .bank  (r_bank),
    .last  (r_last)
  );

  // Writer side: never enters a bank that still holds an unreleased frame.
  assign in_ready    = !bank_full[w_bank];
  assign wr_xfer     = in_valid & in_ready;
  assign w_done      = wr_xfer & w_last;
  assign mem_wr_en   = wr_xfer;
  assign mem_wr_addr = {w_bank, w_ptr};
  assign mem_wr_data = in_data;

  // Reader state is derived from the full flag of the bank it points at.
  always_comb begin
    rd_state = bank_full[r_bank] ? RD_SCAN : RD_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bank_full <= 2'b00;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      out_valid <= rd_issue;
      out_sof   <= rd_issue && (r_ptr == '0);
    end
  end

  // Swap decision uses pre-edge flags, so a frame finishing on the same edge
  // causes one repeat scan. Set and clear can only hit different banks.
  always_comb begin
    r_other       = (r_bank == BANK0) ? BANK1 : BANK0;
    r_end         = rd_issue & r_last;
    r_swap        = r_end & bank_full[r_other];
    bank_full_nxt = bank_full;
    if (w_done) bank_full_nxt[w_bank] = 1'b1;
    if (r_swap) bank_full_nxt[r_bank] = 1'b0;
  end

  always_comb begin
    rd_issue    = (rd_state == RD_SCAN) && out_ready;
    mem_rd_en   = rd_issue;
    mem_rd_addr = {r_bank, r_ptr};
    out_data    = mem_rd_data;
  end

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl with a behavioural data_mem and an output scoreboard.
module tb_frame_buf_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic [1:0]    bank_full;

  int tests = 0;
  int fails = 0;

  logic [DW:0] exp_q[$];
  logic [DW-1:0] mem[0:7];

  always #5 clk = ~clk;

  frame_buf_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sof     (out_sof),
    .bank_full   (bank_full)
  );

  // data_mem: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every out_valid pops the oldest expected {sof, pixel}.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {15'd0, out_sof, out_data}, 32'h0);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        chk("out_data", {16'd0, out_data}, {16'd0, e[DW-1:0]});
        chk("out_sof", {31'd0, out_sof}, {31'd0, e[DW]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [DW-1:0] d, input logic [AW-1:0] a);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk("wr_en", {31'd0, mem_wr_en}, 32'd1);
    chk("wr_addr", {29'd0, mem_wr_addr}, {29'd0, a});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic read_px(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic sof);
    out_ready = 1'b1;
    #1;
    chk("rd_en", {31'd0, mem_rd_en}, 32'd1);
    chk("rd_addr", {29'd0, mem_rd_addr}, {29'd0, a});
    exp_q.push_back({sof, d});
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bank_full", {30'd0, bank_full}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    reset = 1'b1;
    tick();

    // Fill bank 0 with the reader held off.
    for (int i = 0; i < 4; i++) write_px(16'h11 + 16'(i), 3'(i));
    #1;
    chk("fill0_bank_full", {30'd0, bank_full}, 32'h1);
    chk("fill0_in_ready", {31'd0, in_ready}, 32'd1);

    // Scan bank 0 repeatedly: 0,1,2,3,0,1.
    for (int i = 0; i < 6; i++)
      read_px(3'(i % 4), 16'h11 + 16'(i % 4), (i % 4) == 0);
    #1;
    chk("repeat_bank_full", {30'd0, bank_full}, 32'h1);

    // Fill bank 1; both banks full blocks the writer.
    for (int i = 0; i < 4; i++) write_px(16'h21 + 16'(i), 3'(4 + i));
    #1;
    chk("both_bank_full", {30'd0, bank_full}, 32'h3);
    chk("both_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 16'hdead;
    #1;
    chk("blocked_wr_en", {31'd0, mem_wr_en}, 32'd0);
    in_valid = 1'b0;

    // Finish the in-flight scan of bank 0, then swap to bank 1.
    read_px(3'd2, 16'h13, 1'b0);
    read_px(3'd3, 16'h14, 1'b0);
    chk("swap_bank_full", {30'd0, bank_full}, 32'h2);
    chk("swap_in_ready", {31'd0, in_ready}, 32'd1);
    read_px(3'd4, 16'h21, 1'b1);
    read_px(3'd5, 16'h22, 1'b0);
    read_px(3'd6, 16'h23, 1'b0);
    read_px(3'd7, 16'h24, 1'b0);

    // out_ready toggling: stall cycles issue nothing, pixels stay contiguous.
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b0;
      #1;
      chk("stall_rd_en", {31'd0, mem_rd_en}, 32'd0);
      tick();
      read_px(3'(4 + i), 16'h21 + 16'(i), i == 0);
    end

    // Writer completes on the same edge the reader ends a frame: one repeat.
    for (int i = 0; i < 3; i++) write_px(16'h31 + 16'(i), 3'(i));
    for (int i = 0; i < 3; i++) read_px(3'(4 + i), 16'h21 + 16'(i), i == 0);
    in_valid  = 1'b1;
    in_data   = 16'h34;
    out_ready = 1'b1;
    #1;
    chk("coinc_wr_addr", {29'd0, mem_wr_addr}, 32'd3);
    chk("coinc_rd_addr", {29'd0, mem_rd_addr}, 32'd7);
    exp_q.push_back({1'b0, 16'h24});
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("coinc_bank_full", {30'd0, bank_full}, 32'h3);
    for (int i = 0; i < 4; i++) read_px(3'(4 + i), 16'h21 + 16'(i), i == 0);
    chk("after_repeat_bank_full", {30'd0, bank_full}, 32'h1);
    chk("after_repeat_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a write frame and a read frame.
    write_px(16'h41, 3'd4);
    read_px(3'd0, 16'h31, 1'b1);
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h42;
    out_ready = 1'b1;
    tick();
    reset     = 1'b1;
    out_ready = 1'b0;
    in_data   = 16'h51;
    #1;
    chk("midrst_bank_full", {30'd0, bank_full}, 32'h0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_wr_addr", {29'd0, mem_wr_addr}, 32'd0);
    chk("midrst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
